// File: rtl/pe_row_accum.sv
// Row accumulator after the PE: sums KROWS partial-sum rows per lane, then streams requantized pixels.
// Build option: define ROW_ACCUM_ROUND_EN for round-half-up requantization (truncation otherwise).
module pe_row_accum #(
    parameter int NOUT  = 3,
    parameter int PW    = 25,
    parameter int KROWS = 3,
    parameter int ACCW  = 27,
    localparam int IDXW = (NOUT > 1) ? $clog2(NOUT) : 1,
    localparam int RCW  = (KROWS > 1) ? $clog2(KROWS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NOUT*PW-1:0] in_psum,
    input  logic [4:0]        cfg_shift,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [IDXW-1:0]   out_idx,
    output logic              out_last
);

    typedef enum logic {ACC, DRAIN} state_t;

    state_t            state;
    state_t            state_next;
    logic [RCW-1:0]    row_cnt;
    logic [IDXW-1:0]   idx;
    logic [4:0]        shift_q;
    logic [ACCW-1:0]   acc [NOUT];

    logic              row_hs;
    logic              out_hs;
    logic              row_last;
    logic              lane_last;
    logic [ACCW-1:0]   acc_sel;
    logic [ACCW:0]     rnd;
    logic [ACCW:0]     t_val;
    logic [ACCW:0]     s_val;
    logic [7:0]        q_val;

    assign row_hs    = (state == ACC) && in_valid;
    assign out_hs    = (state == DRAIN) && out_ready;
    assign row_last  = (row_cnt == RCW'(KROWS - 1));
    assign lane_last = (idx == IDXW'(NOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (row_hs && row_last) state_next = DRAIN;
            DRAIN:   if (out_hs && lane_last) state_next = ACC;
            default: state_next = ACC;
        endcase
    end

    // The first row of a tile overwrites the accumulators, so no clear cycle is needed between tiles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt <= '0;
            idx     <= '0;
            shift_q <= '0;
            for (int j = 0; j < NOUT; j++) begin
                acc[j] <= '0;
            end
        end else begin
            if (row_hs) begin
                for (int j = 0; j < NOUT; j++) begin
                    if (row_cnt == '0) begin
                        acc[j] <= {{(ACCW-PW){1'b0}}, in_psum[j*PW +: PW]};
                    end else begin
                        acc[j] <= acc[j] + {{(ACCW-PW){1'b0}}, in_psum[j*PW +: PW]};
                    end
                end
                if (row_cnt == '0) begin
                    shift_q <= cfg_shift;
                end
                if (row_last) begin
                    row_cnt <= '0;
                    idx     <= '0;
                end else begin
                    row_cnt <= row_cnt + RCW'(1);
                end
            end
            if (out_hs) begin
                idx <= lane_last ? '0 : idx + IDXW'(1);
            end
        end
    end

    // Requantize at ACCW+1 bits so the rounding addend can never wrap the sum.
    always_comb begin
        acc_sel = acc[idx];
        rnd     = '0;
`ifdef ROW_ACCUM_ROUND_EN
        if (shift_q != 5'd0) begin
            rnd = (ACCW+1)'(1) << (shift_q - 5'd1);
        end
`endif
        t_val = {1'b0, acc_sel} + rnd;
        s_val = t_val >> shift_q;
        q_val = (s_val > (ACCW+1)'(255)) ? 8'd255 : s_val[7:0];
    end

    always_comb begin
        in_ready  = (state == ACC);
        out_valid = (state == DRAIN);
        out_data  = (state == DRAIN) ? q_val : 8'd0;
        out_idx   = idx;
        out_last  = (state == DRAIN) && lane_last;
    end

endmodule

// File: tb/tb_pe_row_accum.sv
// Self-checking bench for pe_row_accum: directed tiles, scoreboard of expected pixels.
// Expected pixels follow the ROW_ACCUM_ROUND_EN build option when it is defined.
module tb_pe_row_accum;

    localparam int NOUT  = 3;
    localparam int PW    = 25;
    localparam int KROWS = 3;
    localparam int ACCW  = 27;

    typedef struct {
        logic [7:0] data;
        logic [1:0] idx;
        logic       last;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [NOUT*PW-1:0] in_psum;
    logic [4:0]        cfg_shift;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [1:0]        out_idx;
    logic              out_last;

    int   compared;
    int   mismatched;
    exp_t sb_q[$];

    longint model_acc [NOUT];
    int     model_shift;
    int     model_rows;

    pe_row_accum #(.NOUT(NOUT), .PW(PW), .KROWS(KROWS), .ACCW(ACCW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .cfg_shift (cfg_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int q_model(input longint x, input int sh);
        longint t;
        t = x;
`ifdef ROW_ACCUM_ROUND_EN
        if (sh > 0) t = t + (longint'(1) << (sh - 1));
`endif
        t = t >> sh;
        return (t > 255) ? 255 : int'(t);
    endfunction

    function automatic void model_reset();
        for (int j = 0; j < NOUT; j++) model_acc[j] = 0;
        model_shift = 0;
        model_rows  = 0;
    endfunction

    // Drives one row handshake and pushes the tile's pixels once its last row is in.
    task automatic apply_stimulus(input int l0, input int l1, input int l2, input int sh);
        int lanes [NOUT];
        exp_t e;
        lanes[0] = l0; lanes[1] = l1; lanes[2] = l2;
        @(negedge clk);
        in_valid  = 1'b1;
        in_psum   = {PW'(l2), PW'(l1), PW'(l0)};
        cfg_shift = 5'(sh);
        check_output("row_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        for (int j = 0; j < NOUT; j++) begin
            if (model_rows == 0) model_acc[j] = lanes[j];
            else model_acc[j] = (model_acc[j] + lanes[j]) % (longint'(1) << ACCW);
        end
        if (model_rows == 0) model_shift = sh;
        model_rows++;
        if (model_rows == KROWS) begin
            model_rows = 0;
            for (int j = 0; j < NOUT; j++) begin
                e.data = 8'(q_model(model_acc[j], model_shift));
                e.idx  = 2'(j);
                e.last = (j == NOUT - 1);
                sb_q.push_back(e);
            end
        end
    endtask

    // Consumes up to 'lanes' pixels, optionally stalling on lane stall_idx while pulsing in_valid.
    task automatic drain(input int stall_idx, input int stall_n, input int lanes);
        int   budget;
        int   done;
        int   stalls;
        exp_t e;
        budget = 0;
        done   = 0;
        stalls = stall_n;
        @(negedge clk);
        check_output("first_pixel_valid", 64'(out_valid), 64'd1);
        while (done < lanes && budget < 40) begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check_output("unexpected_pixel", 64'(out_valid), 64'd0);
                    break;
                end
                e = sb_q[0];
                if (int'(out_idx) == stall_idx && stalls > 0) begin
                    out_ready = 1'b0;
                    in_valid  = 1'b1;
                    in_psum   = {NOUT{PW'($urandom)}};
                    check_output("stall_data", 64'(out_data), 64'(e.data));
                    check_output("stall_idx", 64'(out_idx), 64'(e.idx));
                    check_output("stall_in_ready", 64'(in_ready), 64'd0);
                    stalls--;
                end else begin
                    out_ready = 1'b1;
                    in_valid  = 1'b0;
                    e = sb_q.pop_front();
                    check_output("pix_data", 64'(out_data), 64'(e.data));
                    check_output("pix_idx", 64'(out_idx), 64'(e.idx));
                    check_output("pix_last", 64'(out_last), 64'(e.last));
                    done++;
                end
            end else begin
                out_ready = 1'b1;
                in_valid  = 1'b0;
            end
            @(posedge clk);
            budget++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        if (budget >= 40) check_output("drain_timeout", 64'(done), 64'(lanes));
        if (done == NOUT) begin
            check_output("post_tile_out_valid", 64'(out_valid), 64'd0);
            check_output("post_tile_in_ready", 64'(in_ready), 64'd1);
        end
    endtask

    task automatic send_tile(input int l0, input int l1, input int l2, input int sh);
        for (int r = 0; r < KROWS; r++) apply_stimulus(l0, l1, l2, sh);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_in_ready", 64'(in_ready), 64'd1);
        check_output("rst_out_idx", 64'(out_idx), 64'd0);
        check_output("rst_out_data", 64'(out_data), 64'd0);
        sb_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        model_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_psum   = '0;
        cfg_shift = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_in_ready", 64'(in_ready), 64'd1);
        check_output("reset_out_valid", 64'(out_valid), 64'd0);
        check_output("reset_out_data", 64'(out_data), 64'd0);
        check_output("reset_out_idx", 64'(out_idx), 64'd0);
        check_output("reset_out_last", 64'(out_last), 64'd0);
        rst_n = 1'b1;

        // Basic tile: truncate gives 7,15,22; rounding gives 8,15,23.
        send_tile(10, 20, 30, 2);
        drain(-1, 0, NOUT);

        // Saturation cases.
        send_tile(1000, 1000, 1000, 2);
        drain(-1, 0, NOUT);
        send_tile(85, 0, 1, 0);
        drain(-1, 0, NOUT);

        // Backpressure on lane 1 with ignored in_valid pulses.
        send_tile(5, 6, 7, 0);
        drain(1, 5, NOUT);

        // Shift is taken from the first row only.
        apply_stimulus(4, 8, 12, 2);
        apply_stimulus(4, 8, 12, 0);
        apply_stimulus(4, 8, 12, 0);
        drain(-1, 0, NOUT);

        // Reset with a partial accumulation, then reset mid-drain.
        apply_stimulus(100, 100, 100, 3);
        pulse_reset();
        send_tile(9, 9, 9, 0);
        drain(-1, 0, 1);
        pulse_reset();
        send_tile(1, 1, 1, 0);
        drain(-1, 0, NOUT);

        check_output("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pe_row_accum.md
# pe_row_accum

Downstream stage of the PE convolution row engine. It takes the per-row partial sums produced by the PE (NOUT lanes of PW-bit unsigned sums), accumulates KROWS consecutive kernel-row results into one output tile, then requantizes each lane to 8 bits. It emits the tile one pixel per cycle on a valid/ready stream toward the output feature-map writer.

## Interface
Parameters:
- NOUT, 3 — output lanes per PE row (fsize-ksize+1)
- PW, 25 — width of one PE partial sum
- KROWS, 3 — kernel rows accumulated per tile
- ACCW, 27 — accumulator width per lane (≥ PW + clog2(KROWS))

Ports:
- clk  in  1  — single clock, rising edge
- rst_n  in  1  — reset, asynchronous, active-low
- in_valid  in  1  — PE row result valid
- in_ready  out  1  — block accepts a row
- in_psum  in  NOUT*PW  — lane j at bits [j*PW+PW-1 : j*PW], unsigned
- cfg_shift  in  5  — requantization right-shift, 0..31
- out_valid  out  1  — output pixel valid
- out_ready  in  1  — consumer accepts pixel
- out_data  out  8  — requantized unsigned pixel
- out_idx  out  clog2(NOUT)  — lane index of out_data
- out_last  out  1  — high with the final lane (idx NOUT-1) of a tile

## Operation
- Two states: ACC, DRAIN. Reset state ACC.
- ACC: in_ready=1. Row handshake (in_valid & in_ready):
  - row_cnt==0: acc[j] <= zero-extended in_psum lane j (no separate clear); cfg_shift latched into shift_q.
  - row_cnt>0: acc[j] <= acc[j] + lane j, modulo 2^ACCW (wrap, no saturation).
  - row_cnt==KROWS-1: row_cnt <= 0, go DRAIN, idx <= 0; else row_cnt++.
- DRAIN: in_ready=0. out_valid=1. out_data = q(acc[idx]); out_last = (idx==NOUT-1).
  - Handshake (out_valid & out_ready): idx++; on last lane go ACC.
- q(x): t = x (+ round term, see Configuration) evaluated at ACCW+1 bits, no wrap; s = t >> shift_q; out_data = (s > 255) ? 255 : s[7:0].
- cfg_shift changes after the first row of a tile have no effect on that tile.
- in_valid ignored in DRAIN; in_psum content irrelevant when not handshaking.

## Timing
- Reset values: in_ready=1 (state ACC), out_valid=0, out_data=0, out_idx=0, out_last=0; row_cnt=0, acc=0, shift_q=0.
- in_ready, out_valid, out_idx, out_last are decoded from registers only; no combinational path from in_valid or out_ready to any output.
- Final row handshake at edge N → out_valid=1, out_idx=0 from cycle N+1.
- out_data/out_idx/out_last stable while out_valid & !out_ready.
- Last-lane handshake at edge M → out_valid=0, in_ready=1 from cycle M+1; next row accepted at edge M+1 at the earliest.
- Minimum tile period with no stalls: KROWS + NOUT cycles.
- Reset asserted mid-tile (either state): all state returns to reset values immediately; partial accumulation discarded, no pixel emitted.

## Configuration
- ROW_ACCUM_ROUND_EN defined: round-half-up; t = x + (1 << (shift_q-1)) when shift_q>0, t = x when shift_q==0.
- Not defined: truncation; t = x.
- Saturation to 255 applies in both builds.

## Test plan
- Basic tile, truncate build: shift=2, three rows of lanes {10,20,30} → pixels 7,15,22 with idx 0,1,2, out_last only on 22.
- Round build, same stimulus → 8,15,23.
- Saturation: shift=2, three rows of {1000,1000,1000} → acc 3000, pixels 255,255,255; shift=0 with lanes {85,0,1} ×3 → 255,0,3.
- Backpressure: hold out_ready=0 for 5 cycles on idx 1 → out_data/out_idx unchanged, in_ready stays 0, in_valid pulses ignored; release → idx 2 next, then in_ready=1 the cycle after its handshake.
- Shift latch: shift=2 on row 0, change to 0 on rows 1–2 with {4,8,12} ×3 → pixels 3,6,9 (truncate).
- Reset mid-DRAIN after idx 0 emitted: rst_n low 2 cycles → out_valid=0, in_ready=1; new tile of {1,1,1} ×3, shift=0 → 3,3,3 with no stale data.
